// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM states (HALT is only reachable when FETCH_MISALIGN_TRAP_EN is defined)
//   NOP_INSTR        : instruction presented to decode while nothing live is held
//   PC_INC           : sequential PC step in bytes
//   RESET_PC_DEFAULT : default PC after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {instr, pc} pair that arrived while decode was stalled.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : capture i_instr/i_pc, entry becomes valid
//   i_pop         : entry consumed, becomes empty
//   i_clear       : flush (wins over push and pop)
//   i_instr, i_pc : entry to capture
//   o_valid       : entry held
//   o_instr, o_pc : held entry
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= INSTR_W'(NOP_INSTR);
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues req/ack reads to instruction memory and presents
// {instr, pc, pc+4} to decode, honouring decode stall and EX redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect raises a sticky
// fetch_fault and parks the stage in HALT; without it the redirect target is word-aligned.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   stall                   : decode cannot accept, hold if_* outputs
//   redirect_valid/_pc      : taken branch/jump and its target
//   imem_req/_addr          : fetch request and address (address stable until ack)
//   imem_ack/_rdata         : read completion and instruction
//   if_valid/_instr/_pc/_pc_plus4 : IF/ID outputs
//   fetch_fault             : misaligned redirect trapped (tied 0 without the macro)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               fetch_fault
);

  localparam logic [ADDR_W-1:0]  Inc = ADDR_W'(PC_INC);
  localparam logic [INSTR_W-1:0] Nop = INSTR_W'(NOP_INSTR);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_drop;
  logic [ADDR_W-1:0]  r_drop_addr;  // address of the outstanding request being discarded
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;
  logic [ADDR_W-1:0]  r_if_pc_plus4;

  logic               w_redirect;
  logic [ADDR_W-1:0]  w_target;
  logic               w_xfer;
  logic               w_keep;
  logic               w_push;
  logic               w_pop;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0]  w_skid_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;
  logic w_misalign;
  assign w_redirect  = redirect_valid && (r_state != HALT);
  assign w_misalign  = w_redirect && (redirect_pc[1:0] != 2'b00);
  assign w_target    = redirect_pc;
  assign fetch_fault = r_fault;
`else
  logic w_unused_lsb;
  assign w_redirect   = redirect_valid;
  assign w_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused_lsb = ^redirect_pc[1:0];
  assign fetch_fault  = 1'b0;
`endif

  assign imem_req  = (r_state == REQ);
  // While a discarded request is outstanding the old address stays on the bus.
  assign imem_addr = r_drop ? r_drop_addr : r_pc;

  assign w_xfer = imem_req && imem_ack;
  // Transfer whose data is actually delivered (not dropped, not flushed this cycle).
  assign w_keep = w_xfer && !r_drop && !w_redirect;
  assign w_push = w_keep && stall;
  assign w_pop  = !w_redirect && !stall && w_skid_valid;

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clear(w_redirect),
    .i_instr(imem_rdata),
    .i_pc   (r_pc),
    .o_valid(w_skid_valid),
    .o_instr(w_skid_instr),
    .o_pc   (w_skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_drop        <= 1'b0;
      r_drop_addr   <= '0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= Nop;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_fault       <= 1'b0;
`endif
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
      r_if_instr <= Nop;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_misalign) begin
        r_fault <= 1'b1;
        r_state <= HALT;
        r_drop  <= 1'b0;
      end else
`endif
      begin
        r_pc    <= w_target;
        r_state <= REQ;
        // A request left hanging must still complete at its old address; its data is thrown away.
        r_drop  <= imem_req && !imem_ack;
        if (!r_drop) begin
          r_drop_addr <= r_pc;
        end
      end
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (w_xfer) begin
            r_drop <= 1'b0;
            if (!r_drop) begin
              r_pc <= r_pc + Inc;
            end
            if (w_push) begin
              r_state <= FULL;
            end
          end
        end
        FULL: begin
          if (!stall) begin
            r_state <= REQ;
          end
        end
        default: ;
      endcase

      if (!stall) begin
        if (w_skid_valid) begin
          r_if_valid    <= 1'b1;
          r_if_instr    <= w_skid_instr;
          r_if_pc       <= w_skid_pc;
          r_if_pc_plus4 <= w_skid_pc + Inc;
        end else if (w_keep) begin
          r_if_valid    <= 1'b1;
          r_if_instr    <= imem_rdata;
          r_if_pc       <= r_pc;
          r_if_pc_plus4 <= r_pc + Inc;
        end else begin
          r_if_valid <= 1'b0;
          r_if_instr <= Nop;
        end
      end
    end
  end

  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Asynchronous assert (checked immediately), synchronous release at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_ack = 1'b0;
    #1;
    check("reset req", 32'(imem_req), 32'd0);
    check("reset valid", 32'(if_valid), 32'd0);
    check("reset instr", if_instr, 32'h0);
    check("reset pc", if_pc, 32'h0);
    check("reset pc4", if_pc_plus4, 32'h0);
    check("reset fault", 32'(fetch_fault), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        ak;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        flt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic st, input logic ak, input logic rv, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic flt);
    vec_t v;
    v.st = st; v.ak = ak; v.rv = rv; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.flt = flt;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic        p_req;
    logic        p_ack;
    logic [31:0] p_addr;
    int          deliveries;
    int          tmp;

    //           st ak rv rpc        req addr       vld pc         flt
    vecs[0]  = mk(0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,     0);  // IDLE
    vecs[1]  = mk(0, 1, 0, 32'h0,     1, 32'h0,     0, 32'h0,     0);
    vecs[2]  = mk(0, 1, 0, 32'h0,     1, 32'h4,     1, 32'h0,     0);
    vecs[3]  = mk(0, 0, 0, 32'h0,     1, 32'h8,     1, 32'h4,     0);  // ack withheld at 0x8
    vecs[4]  = mk(0, 0, 0, 32'h0,     1, 32'h8,     0, 32'h0,     0);
    vecs[5]  = mk(0, 0, 0, 32'h0,     1, 32'h8,     0, 32'h0,     0);
    vecs[6]  = mk(0, 1, 0, 32'h0,     1, 32'h8,     0, 32'h0,     0);
    vecs[7]  = mk(0, 1, 0, 32'h0,     1, 32'hC,     1, 32'h8,     0);
    vecs[8]  = mk(1, 1, 0, 32'h0,     1, 32'h10,    1, 32'hC,     0);  // stall x4
    vecs[9]  = mk(1, 1, 0, 32'h0,     0, 32'h0,     1, 32'hC,     0);
    vecs[10] = mk(1, 1, 0, 32'h0,     0, 32'h0,     1, 32'hC,     0);
    vecs[11] = mk(1, 1, 0, 32'h0,     0, 32'h0,     1, 32'hC,     0);
    vecs[12] = mk(0, 1, 0, 32'h0,     0, 32'h0,     1, 32'hC,     0);
    vecs[13] = mk(0, 1, 0, 32'h0,     1, 32'h14,    1, 32'h10,    0);
    vecs[14] = mk(0, 1, 0, 32'h0,     1, 32'h18,    1, 32'h14,    0);
    vecs[15] = mk(0, 1, 0, 32'h0,     1, 32'h1C,    1, 32'h18,    0);
    vecs[16] = mk(0, 0, 1, 32'h100,   1, 32'h20,    1, 32'h1C,    0);  // redirect, ack pending
    vecs[17] = mk(0, 0, 0, 32'h0,     1, 32'h20,    0, 32'h0,     0);
    vecs[18] = mk(0, 1, 0, 32'h0,     1, 32'h20,    0, 32'h0,     0);  // dropped ack
    vecs[19] = mk(0, 1, 0, 32'h0,     1, 32'h100,   0, 32'h0,     0);
    vecs[20] = mk(0, 1, 1, 32'h200,   1, 32'h104,   1, 32'h100,   0);  // redirect + ack
    vecs[21] = mk(0, 1, 0, 32'h0,     1, 32'h200,   0, 32'h0,     0);
    vecs[22] = mk(1, 1, 1, 32'h300,   1, 32'h204,   1, 32'h200,   0);  // redirect + stall + ack
    vecs[23] = mk(0, 1, 0, 32'h0,     1, 32'h300,   0, 32'h0,     0);
    vecs[24] = mk(0, 0, 1, 32'h102,   1, 32'h304,   1, 32'h300,   0);  // misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs[25] = mk(0, 1, 1, 32'h400,   0, 32'h0,     0, 32'h0,     1);  // ignored while halted
    vecs[26] = mk(0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,     1);
    vecs[27] = mk(0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,     1);
`else
    vecs[25] = mk(0, 1, 0, 32'h0,     1, 32'h304,   0, 32'h0,     0);
    vecs[26] = mk(0, 1, 0, 32'h0,     1, 32'h100,   0, 32'h0,     0);
    vecs[27] = mk(0, 1, 0, 32'h0,     1, 32'h104,   1, 32'h100,   0);
`endif

    // Directed table
    do_reset();
    for (int i = 0; i < NV; i++) begin
      stall          = vecs[i].st;
      imem_ack       = vecs[i].ak;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      check($sformatf("row%0d req", i), 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req) check($sformatf("row%0d addr", i), imem_addr, vecs[i].addr);
      check($sformatf("row%0d valid", i), 32'(if_valid), 32'(vecs[i].vld));
      if (vecs[i].vld) begin
        check($sformatf("row%0d if_pc", i), if_pc, vecs[i].pc);
        check($sformatf("row%0d if_pc_plus4", i), if_pc_plus4, vecs[i].pc + 32'd4);
        check($sformatf("row%0d if_instr", i), if_instr, instr_of(vecs[i].pc));
      end else begin
        check($sformatf("row%0d nop", i), if_instr, 32'h0);
      end
      check($sformatf("row%0d fault", i), 32'(fetch_fault), 32'(vecs[i].flt));
      @(posedge clk);
      #1;
    end

    // PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("wrap req", 32'(imem_req), 32'd1);
    check("wrap addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    check("wrap next addr", imem_addr, 32'h0);
    check("wrap valid", 32'(if_valid), 32'd1);
    check("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap if_pc_plus4", if_pc_plus4, 32'h0);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check("wrap2 if_pc", if_pc, 32'h0);
    check("wrap2 if_pc_plus4", if_pc_plus4, 32'h4);

    // Randomized run against an in-order instruction-stream model
    do_reset();
    exp_pc = 32'h0;
    deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 99) < 30);
      imem_ack       = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 4);
      tmp            = int'($urandom_range(0, 255));
      redirect_pc    = 32'(tmp) << 2;
      if (if_valid && !stall && !redirect_valid) begin
        check("rand if_pc", if_pc, exp_pc);
        check("rand if_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
        check("rand if_instr", if_instr, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else if (!if_valid) begin
        check("rand nop", if_instr, 32'h0);
      end
      if (redirect_valid) exp_pc = redirect_pc;
      p_req  = imem_req;
      p_ack  = imem_ack;
      p_addr = imem_addr;
      @(posedge clk);
      #1;
      if (p_req && !p_ack) begin
        check("rand req held", 32'(imem_req), 32'd1);
        check("rand addr held", imem_addr, p_addr);
      end
    end
    check("rand progress", 32'(deliveries > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
